// File: rtl/tdes_pass_sequencer.sv
// Triple DES pass sequencer: runs three single-DES passes (E-D-E or D-E-D)
// through one shared DES core and holds the final block for the AHB slave.
module tdes_pass_sequencer (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        enable,
    input  logic        encryptionType,
    input  logic [63:0] data,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    input  logic        resultRead,
    output logic        des_start,
    output logic        des_decrypt,
    output logic [63:0] des_key,
    output logic [63:0] des_din,
    input  logic        des_done,
    input  logic [63:0] des_dout,
    output logic        busy,
    output logic        outputEnable,
    output logic [63:0] outputData,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        enc_q, enc_d;
    logic [63:0] key1_q, key1_d;
    logic [63:0] key2_q, key2_d;
    logic [63:0] key3_q, key3_d;
    logic [63:0] work_q, work_d;
    logic        start_q, start_d;
    logic        dec_q, dec_d;
    logic [63:0] dkey_q, dkey_d;
    logic        busy_q, busy_d;
    logic        oe_q, oe_d;
    logic [63:0] odata_q, odata_d;
    logic        ovr_q, ovr_d;

    logic        accept_s;
    logic        done_ok_s;
    logic        in_pass_d_s;

    function automatic logic is_pass(input state_t s);
        return (s == S_P1) || (s == S_P2) || (s == S_P3);
    endfunction

    // Encrypt uses k1,k2,k3; decrypt walks the keys backwards.
    function automatic logic [63:0] pass_key(input state_t s, input logic enc,
                                             input logic [63:0] k1,
                                             input logic [63:0] k2,
                                             input logic [63:0] k3);
        logic [63:0] k;
        case (s)
            S_P1:    k = enc ? k1 : k3;
            S_P2:    k = k2;
            S_P3:    k = enc ? k3 : k1;
            default: k = 64'h0;
        endcase
        return k;
    endfunction

    function automatic logic pass_dec(input state_t s, input logic enc);
        logic d;
        case (s)
            S_P1, S_P3: d = ~enc;
            S_P2:       d = enc;
            default:    d = 1'b0;
        endcase
        return d;
    endfunction

    assign accept_s  = enable && ((state_q == S_IDLE) || (state_q == S_DONE));
    // A done coinciding with our own start pulse belongs to no pass.
    assign done_ok_s = des_done && is_pass(state_q) && !start_q;

    // Next-state and next-output computation.
    always_comb begin
        state_d = state_q;
        enc_d   = enc_q;
        key1_d  = key1_q;
        key2_d  = key2_q;
        key3_d  = key3_q;
        work_d  = work_q;
        dec_d   = dec_q;
        dkey_d  = dkey_q;
        oe_d    = oe_q;
        odata_d = odata_q;
        ovr_d   = ovr_q;
        start_d = 1'b0;
        busy_d  = 1'b0;
        in_pass_d_s = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    enc_d   = encryptionType;
                    key1_d  = key1;
                    key2_d  = key2;
                    key3_d  = key3;
                    work_d  = data;
                    ovr_d   = 1'b0;
                    oe_d    = 1'b0;
                    state_d = S_P1;
                end else if ((state_q == S_DONE) && resultRead && oe_q) begin
                    oe_d    = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            S_P1, S_P2, S_P3: begin
                if (enable) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
                if (done_ok_s) begin
                    work_d = des_dout;
                    if (state_q == S_P1) begin
                        state_d = S_P2;
                    end else if (state_q == S_P2) begin
                        state_d = S_P3;
                    end else begin
                        state_d = S_DONE;
                        odata_d = des_dout;
                        oe_d    = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_pass_d_s = is_pass(state_d);
        busy_d      = in_pass_d_s;
        // Key and direction are registered from the upcoming state so they
        // are already valid alongside the start pulse and hold for the pass.
        if (in_pass_d_s) begin
            dkey_d  = pass_key(state_d, enc_d, key1_d, key2_d, key3_d);
            dec_d   = pass_dec(state_d, enc_d);
            start_d = (state_d != state_q);
        end else begin
            dkey_d  = dkey_q;
            dec_d   = dec_q;
            start_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q <= S_IDLE;
            enc_q   <= 1'b0;
            key1_q  <= 64'h0;
            key2_q  <= 64'h0;
            key3_q  <= 64'h0;
            work_q  <= 64'h0;
            start_q <= 1'b0;
            dec_q   <= 1'b0;
            dkey_q  <= 64'h0;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
            odata_q <= 64'h0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            enc_q   <= enc_d;
            key1_q  <= key1_d;
            key2_q  <= key2_d;
            key3_q  <= key3_d;
            work_q  <= work_d;
            start_q <= start_d;
            dec_q   <= dec_d;
            dkey_q  <= dkey_d;
            busy_q  <= busy_d;
            oe_q    <= oe_d;
            odata_q <= odata_d;
            ovr_q   <= ovr_d;
        end
    end

    assign des_start    = start_q;
    assign des_decrypt  = dec_q;
    assign des_key      = dkey_q;
    assign des_din      = work_q;
    assign busy         = busy_q;
    assign outputEnable = oe_q;
    assign outputData   = odata_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_tdes_pass_sequencer.sv
// Directed bench for tdes_pass_sequencer with an XOR behavioural DES core.
module tb_tdes_pass_sequencer;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b0;
    logic        enable = 1'b0;
    logic        encryptionType = 1'b0;
    logic [63:0] data = 64'h0;
    logic [63:0] key1 = 64'h0;
    logic [63:0] key2 = 64'h0;
    logic [63:0] key3 = 64'h0;
    logic        resultRead = 1'b0;
    logic        des_start, des_decrypt, busy, outputEnable, overrun;
    logic [63:0] des_key, des_din, outputData;
    logic        des_done;
    logic [63:0] des_dout;
    logic        core_done;
    logic        man_done = 1'b0;

    assign des_done = core_done | man_done;

    tdes_pass_sequencer dut (
        .HCLK(HCLK), .HRESET(HRESET), .enable(enable),
        .encryptionType(encryptionType), .data(data),
        .key1(key1), .key2(key2), .key3(key3), .resultRead(resultRead),
        .des_start(des_start), .des_decrypt(des_decrypt), .des_key(des_key),
        .des_din(des_din), .des_done(des_done), .des_dout(des_dout),
        .busy(busy), .outputEnable(outputEnable), .outputData(outputData),
        .overrun(overrun)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // Behavioural core: dout = din ^ key, done sampled L edges after start.
    localparam int L = 4;
    int          cnt;
    int          pass_cnt = 0;
    logic [63:0] res_q;
    logic [63:0] rk[64];
    logic        rd[64];
    logic [63:0] rdin[64];

    always @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            cnt       <= 0;
            core_done <= 1'b0;
            des_dout  <= 64'h0;
            res_q     <= 64'h0;
        end else begin
            core_done <= 1'b0;
            if (des_start) begin
                cnt                  <= L - 1;
                res_q                <= des_din ^ des_key;
                rk[pass_cnt % 64]    <= des_key;
                rd[pass_cnt % 64]    <= des_decrypt;
                rdin[pass_cnt % 64]  <= des_din;
                pass_cnt             <= pass_cnt + 1;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    core_done <= 1'b1;
                    des_dout  <= res_q;
                end
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int acc_edge = 0;
    int base = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic enc, input logic [63:0] d, input logic [63:0] k1,
                            input logic [63:0] k2, input logic [63:0] k3, input logic rr);
        @(negedge HCLK);
        encryptionType = enc; data = d; key1 = k1; key2 = k2; key3 = k3;
        enable = 1'b1; resultRead = rr;
        base = pass_cnt;
        @(negedge HCLK);
        enable = 1'b0; resultRead = 1'b0;
        acc_edge = cyc;
        // Scramble inputs: the captured copy must be what the passes use.
        encryptionType = ~enc; data = ~d; key1 = ~k1; key2 = ~k2; key3 = ~k3;
    endtask

    task automatic wait_oe(input string name);
        int lat;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (outputEnable) begin
                lat = cyc - acc_edge;
                break;
            end
            @(negedge HCLK);
        end
        chk({name, "_latency"}, 64'(lat), 64'd15);
    endtask

    task automatic wait_pass(input int n);
        for (int i = 0; i < 200; i++) begin
            if (pass_cnt >= base + n) break;
            @(negedge HCLK);
        end
        chk("wait_pass", 64'(pass_cnt - base), 64'(n));
    endtask

    task automatic read_result();
        @(negedge HCLK);
        resultRead = 1'b1;
        @(negedge HCLK);
        resultRead = 1'b0;
        chk("read_oe_clear", {63'h0, outputEnable}, 64'h0);
    endtask

    typedef struct {
        logic        enc;
        logic [63:0] din, k1, k2, k3, expo;
        logic [63:0] ek0, ek1, ek2;
        logic [2:0]  ed;     // {pass3, pass2, pass1}
    } vec_t;

    vec_t vecs[4];
    logic [63:0] held;
    int          pc;

    initial begin
        vecs[0] = '{1'b1, 64'h0, 64'h1111111111111111, 64'h2222222222222222,
                    64'h4444444444444444, 64'h7777777777777777,
                    64'h1111111111111111, 64'h2222222222222222, 64'h4444444444444444, 3'b010};
        vecs[1] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h1111111111111111, 64'h2222222222222222,
                    64'h4444444444444444, 64'h8888888888888888,
                    64'h4444444444444444, 64'h2222222222222222, 64'h1111111111111111, 3'b101};
        vecs[2] = '{1'b1, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F,
                    64'hF0F0F0F0F0F0F0F0, 64'h0,
                    64'hFEDCBA9876543210, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 3'b010};
        vecs[3] = '{1'b0, 64'h0, 64'h1, 64'h2, 64'h8, 64'hB,
                    64'h8, 64'h2, 64'h1, 3'b101};

        // Reset state
        #12;
        chk("rst_des_start", {63'h0, des_start}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_oe", {63'h0, outputEnable}, 64'h0);
        chk("rst_overrun", {63'h0, overrun}, 64'h0);
        chk("rst_des_key", des_key, 64'h0);
        chk("rst_des_din", des_din, 64'h0);
        chk("rst_outdata", outputData, 64'h0);
        chk("rst_des_dec", {63'h0, des_decrypt}, 64'h0);
        @(negedge HCLK);
        HRESET = 1'b1;

        // Spurious des_done in IDLE
        @(negedge HCLK);
        man_done = 1'b1;
        @(negedge HCLK);
        man_done = 1'b0;
        @(negedge HCLK);
        chk("idle_done_busy", {63'h0, busy}, 64'h0);
        chk("idle_done_start", {63'h0, des_start}, 64'h0);
        chk("idle_done_oe", {63'h0, outputEnable}, 64'h0);
        chk("idle_done_passes", 64'(pass_cnt), 64'h0);

        // Table-driven sequencing vectors
        for (int v = 0; v < 4; v++) begin
            start_op(vecs[v].enc, vecs[v].din, vecs[v].k1, vecs[v].k2, vecs[v].k3, 1'b0);
            chk("acc_busy", {63'h0, busy}, 64'h1);
            chk("acc_start", {63'h0, des_start}, 64'h1);
            wait_oe("vec");
            chk("vec_out", outputData, vecs[v].expo);
            chk("vec_passes", 64'(pass_cnt - base), 64'd3);
            chk("vec_din1", rdin[base % 64], vecs[v].din);
            chk("vec_key1", rk[base % 64], vecs[v].ek0);
            chk("vec_key2", rk[(base + 1) % 64], vecs[v].ek1);
            chk("vec_key3", rk[(base + 2) % 64], vecs[v].ek2);
            chk("vec_dec1", {63'h0, rd[base % 64]}, {63'h0, vecs[v].ed[0]});
            chk("vec_dec2", {63'h0, rd[(base + 1) % 64]}, {63'h0, vecs[v].ed[1]});
            chk("vec_dec3", {63'h0, rd[(base + 2) % 64]}, {63'h0, vecs[v].ed[2]});
            chk("vec_busy_done", {63'h0, busy}, 64'h0);
            read_result();
        end

        // Result hold for 10 cycles, then read
        start_op(1'b1, 64'h0, 64'h1111111111111111, 64'h2222222222222222,
                 64'h4444444444444444, 1'b0);
        wait_oe("hold");
        held = outputData;
        chk("hold_val", held, 64'h7777777777777777);
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            chk("hold_oe", {63'h0, outputEnable}, 64'h1);
        end
        read_result();
        chk("hold_data_after_read", outputData, 64'h7777777777777777);
        chk("hold_busy_after_read", {63'h0, busy}, 64'h0);

        // Overrun: enable during P2
        start_op(1'b1, 64'h0, 64'h1111111111111111, 64'h2222222222222222,
                 64'h4444444444444444, 1'b0);
        wait_pass(2);
        @(negedge HCLK);
        data = 64'hDEADBEEFDEADBEEF; key1 = 64'h5; enable = 1'b1;
        @(negedge HCLK);
        enable = 1'b0;
        chk("ovr_set", {63'h0, overrun}, 64'h1);
        wait_oe("ovr");
        chk("ovr_out", outputData, 64'h7777777777777777);
        chk("ovr_passes", 64'(pass_cnt - base), 64'd3);
        read_result();
        chk("ovr_sticky", {63'h0, overrun}, 64'h1);
        start_op(1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h1111111111111111, 64'h2222222222222222,
                 64'h4444444444444444, 1'b0);
        chk("ovr_cleared", {63'h0, overrun}, 64'h0);
        wait_oe("ovr2");
        chk("ovr2_out", outputData, 64'h8888888888888888);

        // enable together with resultRead in DONE: enable wins
        start_op(1'b1, 64'h0, 64'h1, 64'h2, 64'h4, 1'b1);
        chk("both_busy", {63'h0, busy}, 64'h1);
        chk("both_oe", {63'h0, outputEnable}, 64'h0);
        chk("both_start", {63'h0, des_start}, 64'h1);
        wait_oe("both");
        chk("both_out", outputData, 64'h7);

        // des_done while des_start is high must be ignored
        start_op(1'b0, 64'h10, 64'h1, 64'h2, 64'h4, 1'b0);
        man_done = 1'b1;
        @(negedge HCLK);
        man_done = 1'b0;
        wait_oe("startdone");
        chk("startdone_out", outputData, 64'h17);
        read_result();

        // Reset in P2
        start_op(1'b1, 64'h0, 64'h1111111111111111, 64'h2222222222222222,
                 64'h4444444444444444, 1'b0);
        wait_pass(2);
        @(negedge HCLK);
        #2 HRESET = 1'b0;
        #1;
        chk("mid_rst_busy", {63'h0, busy}, 64'h0);
        chk("mid_rst_start", {63'h0, des_start}, 64'h0);
        chk("mid_rst_key", des_key, 64'h0);
        chk("mid_rst_din", des_din, 64'h0);
        chk("mid_rst_out", outputData, 64'h0);
        chk("mid_rst_dec", {63'h0, des_decrypt}, 64'h0);
        repeat (2) @(negedge HCLK);
        HRESET = 1'b1;
        pc = pass_cnt;
        repeat (20) @(negedge HCLK);
        chk("post_rst_no_start", 64'(pass_cnt), 64'(pc));
        chk("post_rst_oe", {63'h0, outputEnable}, 64'h0);
        chk("post_rst_busy", {63'h0, busy}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tdes_pass_sequencer.md
# tdes_pass_sequencer

Sequences the three DES passes of a Triple DES operation through one shared single-DES core. It sits between the AHB-Lite slave controller and the DES core. It latches the configured keys, mode and data block on the controller's start pulse, then drives the core three times in E-D-E (encrypt) or D-E-D (decrypt) order. It returns the final block to the slave's read path with an output-valid flag.

## Interface
- No parameters; all widths are fixed at 64-bit block and key.
- HCLK  in  1  system clock, rising edge.
- HRESET  in  1  reset; asynchronous, active-low.
- enable  in  1  start request, one-cycle pulse from the slave controller.
- encryptionType  in  1  1 = encrypt (E-D-E), 0 = decrypt (D-E-D).
- data  in  64  input block.
- key1, key2, key3  in  64 each  Triple DES keys.
- resultRead  in  1  slave has consumed the result; clears outputEnable.
- des_start  out  1  one-cycle start pulse to the DES core.
- des_decrypt  out  1  pass direction to the core; 1 = decrypt.
- des_key  out  64  key for the current pass.
- des_din  out  64  block for the current pass.
- des_done  in  1  one-cycle pulse from the core when des_dout is valid.
- des_dout  in  64  core result.
- busy  out  1  high while a pass is in flight.
- outputEnable  out  1  result valid.
- outputData  out  64  final Triple DES result.
- overrun  out  1  sticky flag: enable arrived while busy.

## Operation
- States:
  - IDLE: no operation in progress.
  - P1, P2, P3: one state per DES pass.
  - DONE: result held for the slave.
- Pass order for encrypt: P1 = E(key1), P2 = D(key2), P3 = E(key3).
- Pass order for decrypt: P1 = D(key3), P2 = E(key2), P3 = D(key1).
- Start acceptance:
  - enable is accepted only in IDLE or DONE.
  - On acceptance, data, encryptionType and the three keys are captured into internal registers, and the state goes to P1.
  - Input changes after capture have no effect on the operation in flight.
- Pass handoff:
  - On des_done in Pn, des_dout is captured into the working register.
  - P1 moves to P2, and P2 moves to P3.
  - P3 moves to DONE. In the same edge, outputData is loaded with des_dout and outputEnable is set.
- des_din is driven from the working register, and des_key and des_decrypt are decoded from the state. All three are stable for the whole pass.
- des_start pulses for exactly one cycle on entry to each of P1, P2 and P3.
- busy = state is P1, P2 or P3.
- resultRead:
  - In DONE with outputEnable high, resultRead clears outputEnable and returns the state to IDLE.
  - outputData keeps its value until the next completed operation.
- enable while busy: the request is ignored and overrun is set. overrun is cleared only on the next accepted start.
- enable and resultRead in the same DONE cycle: enable wins. The new operation starts and outputEnable clears.
- des_done is ignored in IDLE or DONE, and in any cycle where des_start is high.

## Timing
- Reset values:
  - State is IDLE.
  - des_start, des_decrypt, busy, outputEnable and overrun are 0.
  - des_key, des_din and outputData are 64'h0.
  - The captured registers and the working register are 0.
- Reset mid-operation aborts immediately. No further des_start is issued, and outputEnable stays 0. The core shares HRESET.
- Acceptance at edge 0:
  - des_start is high in the cycle following edge 0.
  - busy is high from edge 0.
- Handoff: des_done sampled at edge t causes des_start to go high in the cycle following edge t.
- End-to-end latency: with a core that returns des_done L edges after sampling des_start, outputEnable rises 3(L+1) edges after the acceptance edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Encrypt sequencing:
  - Stimulus: behavioural core with des_dout = des_din ^ des_key and L = 4; keys 1111111111111111, 2222222222222222, 4444444444444444; data 0000000000000000; encryptionType = 1.
  - Required: des_key sequence k1, k2, k3; des_decrypt sequence 0, 1, 0; outputData 7777777777777777; outputEnable at edge 15.
- Decrypt sequencing:
  - Stimulus: same keys and core model; data FFFFFFFFFFFFFFFF; encryptionType = 0.
  - Required: key order k3, k2, k1; des_decrypt sequence 1, 0, 1; outputData 8888888888888888.
- Overrun:
  - Stimulus: pulse enable during P2.
  - Required: operation completes unaffected and overrun = 1. The next accepted enable clears overrun.
- Result hold and read:
  - Stimulus: after DONE, leave resultRead low for 10 cycles, then pulse it.
  - Required: outputEnable stays 1 for the 10 cycles, then clears; outputData is unchanged.
  - Stimulus: enable together with resultRead in DONE.
  - Required: new operation starts.
- Reset and glitch handling:
  - Stimulus: assert HRESET low in P2.
  - Required: all outputs return to reset values asynchronously, and no des_start follows release.
  - Stimulus: spurious des_done in IDLE.
  - Required: no state change.
